// File: rtl/alu_onehot_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_onehot_decode_pipe
// Description : ALU control-code to one-hot decoder feeding a 2-entry FIFO
//               with valid/ready handshakes on both sides. Optional
//               saturating illegal-code counter under ALU_DEC_ILLEGAL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_onehot_decode_pipe #(
    parameter int SEL_W    = 4,
    parameter int OUT_N    = 10,
    parameter int ALT_CODE = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] out_onehot,
    output logic             out_illegal,
    input  logic             illegal_clr,
    output logic [7:0]       illegal_cnt
);

    localparam logic [OUT_N-1:0] c_bit0  = OUT_N'(1);
    localparam logic [1:0]       c_depth = 2'd2;

    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_in_ready;
    logic [OUT_N-1:0] r_mem_onehot [2];
    logic             r_mem_illegal [2];

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;
    logic [31:0]      w_sel_ext;
    logic [OUT_N-1:0] w_dec_onehot;
    logic             w_dec_illegal;
    logic             w_low_hit;

    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_sel_ext = 32'(in_sel);

    // Low codes take priority, so an ALT_CODE below OUT_N-1 decodes normally.
    always_comb begin
        w_dec_onehot  = '0;
        w_dec_illegal = 1'b0;
        w_low_hit     = 1'b0;
        for (int i = 0; i < OUT_N - 1; i++) begin
            if (w_sel_ext == 32'(i)) begin
                w_dec_onehot[i] = 1'b1;
                w_low_hit       = 1'b1;
            end
        end
        if (!w_low_hit) begin
            if (w_sel_ext == 32'(ALT_CODE)) begin
                w_dec_onehot[OUT_N-1] = 1'b1;
            end else begin
                w_dec_onehot  = c_bit0;
                w_dec_illegal = 1'b1;
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count          <= 2'd0;
            r_wr_ptr         <= 1'b0;
            r_rd_ptr         <= 1'b0;
            r_in_ready       <= 1'b0;
            r_mem_onehot[0]  <= c_bit0;
            r_mem_onehot[1]  <= c_bit0;
            r_mem_illegal[0] <= 1'b0;
            r_mem_illegal[1] <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != c_depth);
            if (w_push) begin
                r_mem_onehot[r_wr_ptr]  <= w_dec_onehot;
                r_mem_illegal[r_wr_ptr] <= w_dec_illegal;
                r_wr_ptr                <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_count != 2'd0);
    assign out_onehot  = out_valid ? r_mem_onehot[r_rd_ptr] : c_bit0;
    assign out_illegal = out_valid & r_mem_illegal[r_rd_ptr];

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [7:0] r_illegal_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= 8'd0;
        end else if (illegal_clr) begin
            r_illegal_cnt <= 8'd0;
        end else if (w_push && w_dec_illegal && (r_illegal_cnt != 8'hFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 8'd1;
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = illegal_clr;
    assign illegal_cnt  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_onehot_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_onehot_decode_pipe
// Description : Directed scoreboard bench for alu_onehot_decode_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_onehot_decode_pipe;

    localparam int SEL_W    = 4;
    localparam int OUT_N    = 10;
    localparam int ALT_CODE = 13;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_N-1:0] out_onehot;
    logic             out_illegal;
    logic             illegal_clr;
    logic [7:0]       illegal_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int model_cnt = 0;
    logic [OUT_N:0] sb_q [$];

    alu_onehot_decode_pipe #(.SEL_W(SEL_W), .OUT_N(OUT_N), .ALT_CODE(ALT_CODE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sel      (in_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_onehot  (out_onehot),
        .out_illegal (out_illegal),
        .illegal_clr (illegal_clr),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    // Returns {illegal, onehot}.
    function automatic logic [OUT_N:0] model_dec(input int code);
        logic [OUT_N:0] r;
        r = '0;
        if (code < OUT_N - 1)      r[code] = 1'b1;
        else if (code == ALT_CODE) r[OUT_N-1] = 1'b1;
        else begin
            r[0]     = 1'b1;
            r[OUT_N] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("stale_output", 32'(out_onehot), 32'h0);
            end else begin
                logic [OUT_N:0] e;
                e = sb_q.pop_front();
                chk("sb_onehot", 32'(out_onehot), 32'(e[OUT_N-1:0]));
                chk("sb_illegal", 32'(out_illegal), 32'(e[OUT_N]));
            end
        end
        if (out_valid) chk("onehot_exact1", 32'($countones(out_onehot)), 32'd1);
        if (in_valid && in_ready) sb_q.push_back(model_dec(int'(in_sel)));
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        if (!rst_n) model_cnt = 0;
        else if (illegal_clr) model_cnt = 0;
        else if (in_valid && in_ready && model_dec(int'(in_sel))[OUT_N] && model_cnt < 255)
            model_cnt++;
`endif
    end

    task automatic push(input int code);
        in_valid = 1'b1;
        in_sel   = SEL_W'(code);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0;
        out_ready = 1'b1; illegal_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_onehot", 32'(out_onehot), 32'h001);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Legal codes back to back, one cycle latency each.
        for (int c = 0; c < 9; c++) begin
            push(c);
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("lat_onehot", 32'(out_onehot), 32'(32'h1 << c));
        end
        push(13);
        chk("alt_onehot", 32'(out_onehot), 32'h200);
        chk("alt_illegal", 32'(out_illegal), 32'd0);
        drain();

        push(9); push(14); push(15);
        drain();
        chk("cnt_after_3", 32'(illegal_cnt), 32'(model_cnt));

        // Fill while stalled; third code must be refused.
        out_ready = 1'b0;
        push(2);
        push(3);
        chk("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_sel = 4'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("full_hold_onehot", 32'(out_onehot), 32'h004);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        chk("second_out", 32'(out_onehot), 32'h008);
        drain();

        // Simultaneous push and pop at occupancy 1.
        out_ready = 1'b0;
        push(1);
        in_valid = 1'b1; in_sel = 4'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pp_ready", 32'(in_ready), 32'd1);
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_onehot", 32'(out_onehot), 32'h020);
        drain();

        // Saturation and clear-wins.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) push(15 - (i % 2));
        drain();
        chk("cnt_sat", 32'(illegal_cnt), 32'(model_cnt));
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        chk("cnt_sat_255", 32'(illegal_cnt), 32'd255);
`endif
        illegal_clr = 1'b1;
        push(9);
        illegal_clr = 1'b0;
        chk("cnt_clr_wins", 32'(illegal_cnt), 32'd0);
        drain();

        // Asynchronous reset with two entries buffered.
        out_ready = 1'b0;
        push(6); push(7);
        #3;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_cnt", 32'(illegal_cnt), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("no_stale", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_onehot_decode_pipe.md
ALU_ONEHOT_DECODE_PIPE -- requirements
Module: alu_onehot_decode_pipe

Interface
REQ-001 SHALL have parameter SEL_W, default 4, width of the ALU control code.
REQ-002 SHALL have parameter OUT_N, default 10, one-hot output width; legal range 2..2**SEL_W.
REQ-003 SHALL have parameter ALT_CODE, default 13, the code mapped to the top one-hot bit.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, input code present.
REQ-007 SHALL have port in_ready, output, 1, block accepts a code this cycle.
REQ-008 SHALL have port in_sel, input, SEL_W, ALU control code.
REQ-009 SHALL have port out_valid, output, 1, decoded entry available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the entry.
REQ-011 SHALL have port out_onehot, output, OUT_N, decoded one-hot vector.
REQ-012 SHALL have port out_illegal, output, 1, entry came from an unmapped code.
REQ-013 SHALL have port illegal_clr, input, 1, synchronous clear of the illegal counter.
REQ-014 SHALL have port illegal_cnt, output, 8, saturating illegal-code count.

Function
REQ-015 SHALL map code c with c < OUT_N-1 to the vector with only bit c set.
REQ-016 SHALL map code ALT_CODE to the vector with only bit OUT_N-1 set, unless ALT_CODE < OUT_N-1, in which case REQ-015 applies.
REQ-017 SHALL map every other code to the vector with only bit 0 set and out_illegal=1.
REQ-018 SHALL always present exactly one set bit on out_onehot while out_valid=1.
REQ-019 SHALL accept an input on a cycle where in_valid and in_ready are both 1 (push).
REQ-020 SHALL complete an output transfer on a cycle where out_valid and out_ready are both 1 (pop).
REQ-021 SHALL buffer decoded entries in a 2-entry in-order FIFO holding the one-hot vector and illegal flag.
REQ-022 SHALL present a pushed entry on out_valid one cycle after the push when the FIFO was empty: one cycle of latency, with no combinational in-to-out path.
REQ-023 SHALL drive in_ready as registered (occupancy < 2), with no combinational dependence on out_ready.
REQ-024 SHALL perform a push and a pop in the same cycle at occupancy 1, leaving occupancy at 1 and advancing the head.
REQ-025 SHALL leave occupancy at 2 with in_ready=0 when full, and a pop from full SHALL raise in_ready on the next cycle.
REQ-026 SHALL hold out_onehot and out_illegal stable while out_valid=1 and out_ready=0.
REQ-027 SHALL drive out_onehot to the bit-0 vector and out_illegal=0 when empty (out_valid=0).
REQ-028 SHALL wrap the read and write pointers modulo 2.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronously), force occupancy=0, out_valid=0, in_ready=0, out_onehot=bit-0 vector, out_illegal=0 and illegal_cnt=0.
REQ-030 SHALL raise in_ready on the first rising clk edge after rst_n deasserts.
REQ-031 SHALL discard buffered entries when reset is asserted mid-operation, so that no stale entry appears after release.

Configuration
REQ-032 SHALL, with macro ALU_DEC_ILLEGAL_CNT_EN defined, increment illegal_cnt by 1 on each push of an illegal code and saturate it at 255.
REQ-033 SHALL, with ALU_DEC_ILLEGAL_CNT_EN defined, make illegal_clr zero illegal_cnt on the next edge; when illegal_clr coincides with an illegal push, the clear SHALL win and the result SHALL be 0.
REQ-034 SHALL, without ALU_DEC_ILLEGAL_CNT_EN, hold illegal_cnt at constant 0, ignore illegal_clr and implement no counter flops; out_illegal is unaffected by the macro.

Verification
REQ-035 SHALL cover this scenario: default parameters, out_ready=1, push codes 0..8 then 13 on consecutive cycles -> out_onehot 0x001, 0x002 ... 0x100, 0x200 one cycle after each push, out_illegal=0.
REQ-036 SHALL cover this scenario: push code 9, 14, 15 -> out_onehot 0x001 with out_illegal=1; with the macro, illegal_cnt=3.
REQ-037 SHALL cover this scenario: out_ready=0, push codes 2, 3, 4 -> only 2 and 3 accepted, in_ready=0 after the second push; set out_ready=1 -> 0x004 then 0x008 in order, then in_ready=1.
REQ-038 SHALL cover this scenario: occupancy 1 with simultaneous push of 5 and pop -> occupancy stays 1 and the next output is 0x020.
REQ-039 SHALL cover this scenario: with the macro, 300 illegal pushes -> illegal_cnt=255; illegal_clr pulsed together with an illegal push -> illegal_cnt=0.
REQ-040 SHALL cover this scenario: rst_n pulled low between edges with 2 entries buffered -> out_valid=0 and illegal_cnt=0 immediately; after release, no stale output and in_ready=1 after one edge.
